// File: rtl/fft_frame_arbiter.sv
// rtl/fft_frame_arbiter.sv - frame-granular two-channel arbiter and output tagger for a shared FFT core
// Optional feature macro: FFT_ARB_FIXED_PRIO_EN (ch0 always wins simultaneous requests).
module fft_frame_arbiter #(
  parameter int FFT_STAGE = 11,
  parameter int DW        = 12,
  parameter int MIN_GAP   = 0,
  parameter int TAG_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          S0_VALID,
  output logic          S0_READY,
  input  logic [DW-1:0] S0_REAL,
  input  logic [DW-1:0] S0_IMAG,
  input  logic          S1_VALID,
  output logic          S1_READY,
  input  logic [DW-1:0] S1_REAL,
  input  logic [DW-1:0] S1_IMAG,
  output logic          CORE_IEN,
  output logic [DW-1:0] CORE_IREAL,
  output logic [DW-1:0] CORE_IIMAG,
  input  logic          CORE_OEN,
  output logic          O_CH,
  output logic          O_SOF,
  output logic          O_EOF,
  output logic          UNDERRUN,
  output logic          TAG_ERR
);
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [TW:0]   TAG_FULL_CNT = (TW+1)'(TAG_DEPTH);
  localparam logic [GW-1:0] GAP_LAST     = GW'(MIN_GAP - 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t               state, state_nxt;
  logic [FFT_STAGE-1:0] cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 gnt_ch;
  logic                 any_req, win_ch, grant, cnt_last;
  logic                 gnt_valid;
  logic [DW-1:0]        gnt_real, gnt_imag;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [TW-1:0]        wr_ptr, rd_ptr;
  logic [TW:0]          tag_cnt;
  logic                 tag_full, tag_empty, tag_pop;
  logic [FFT_STAGE-1:0] oen_cnt;

  assign any_req  = S0_VALID | S1_VALID;
  assign cnt_last = &cnt;

`ifdef FFT_ARB_FIXED_PRIO_EN
  assign win_ch = ~S0_VALID;
`else
  logic rr_ptr;
  // rr_ptr holds the last granted channel; the other one wins a tie
  assign win_ch = (S0_VALID & S1_VALID) ? ~rr_ptr : ~S0_VALID;

  // Round-robin pointer follows every grant
  always_ff @(posedge CLK) begin
    if (!RSTN)      rr_ptr <= 1'b1;
    else if (grant) rr_ptr <= win_ch;
  end
`endif

  assign gnt_valid = gnt_ch ? S1_VALID : S0_VALID;
  assign gnt_real  = gnt_ch ? S1_REAL  : S0_REAL;
  assign gnt_imag  = gnt_ch ? S1_IMAG  : S0_IMAG;
  assign S0_READY  = (state == STREAM) & ~gnt_ch;
  assign S1_READY  = (state == STREAM) &  gnt_ch;

  // Next-state and grant decision; a grant is also the tag push
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !tag_full) begin
          grant     = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (cnt_last) begin
          if (MIN_GAP > 0)                state_nxt = GAP;
          else if (any_req && !tag_full)  grant     = 1'b1;
          else                            state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, frame counters and the registered core input stage
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      gnt_ch     <= 1'b0;
      CORE_IEN   <= 1'b0;
      CORE_IREAL <= '0;
      CORE_IIMAG <= '0;
      UNDERRUN   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_ch <= win_ch;
        cnt    <= '0;
      end else if (state == STREAM) begin
        cnt <= cnt + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == STREAM) begin
        CORE_IEN <= 1'b1;
        if (gnt_valid) begin
          CORE_IREAL <= gnt_real;
          CORE_IIMAG <= gnt_imag;
        end else begin
          // keep the frame length fixed: inject a zero sample instead
          CORE_IREAL <= '0;
          CORE_IIMAG <= '0;
          UNDERRUN   <= 1'b1;
        end
      end else begin
        CORE_IEN   <= 1'b0;
        CORE_IREAL <= '0;
        CORE_IIMAG <= '0;
      end
    end
  end

  assign tag_full  = (tag_cnt == TAG_FULL_CNT);
  assign tag_empty = (tag_cnt == '0);
  assign tag_pop   = CORE_OEN & (&oen_cnt) & ~tag_empty;

  // In-order channel tag FIFO plus the output sample counter
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      oen_cnt <= '0;
      TAG_ERR <= 1'b0;
    end else begin
      if (grant) begin
        tag_mem[wr_ptr] <= win_ch;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (tag_pop) rd_ptr <= rd_ptr + 1'b1;
      if (grant && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (!grant && tag_pop) tag_cnt <= tag_cnt - 1'b1;
      if (CORE_OEN) oen_cnt <= oen_cnt + 1'b1;
      if (CORE_OEN && tag_empty) TAG_ERR <= 1'b1;
    end
  end

  assign O_CH  = CORE_OEN & ~tag_empty & tag_mem[rd_ptr];
  assign O_SOF = CORE_OEN & (oen_cnt == '0);
  assign O_EOF = CORE_OEN & (&oen_cnt);

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares the single FFT/IFFT core between two streaming sample sources (ch0, ch1). Grants the core one whole frame (N = 2^FFT_STAGE samples) at a time and drives the core's IEN/IREAL/IIMAG inputs.
- Tags each core output frame (OEN bursts) with the channel that produced it, using a small in-order tag FIFO.
- Sits between the sample sources and the core's input pins, and monitors the core's output pins.

Parameters:
- FFT_STAGE, 11, log2 of frame length N.
- DW, 12, sample width per real/imag component.
- MIN_GAP, 0, minimum idle cycles with CORE_IEN=0 between consecutive frames.
- TAG_DEPTH, 4, tag FIFO depth (power of 2, ≥2).

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset: synchronous, active-low
- S0_VALID  in  1  ch0 sample valid
- S0_READY  out  1  ch0 sample accepted
- S0_REAL, S0_IMAG  in  DW each  ch0 sample
- S1_VALID, S1_READY, S1_REAL, S1_IMAG  same as ch0, for ch1
- CORE_IEN  out  1  core input enable
- CORE_IREAL, CORE_IIMAG  out  DW each  core input sample
- CORE_OEN  in  1  core output valid
- O_CH  out  1  channel tag of the current output sample
- O_SOF  out  1  first output sample of a frame
- O_EOF  out  1  last output sample of a frame
- UNDERRUN  out  1  sticky: source starved mid-frame
- TAG_ERR  out  1  sticky: CORE_OEN seen with tag FIFO empty

Behaviour:
- Reset values: all outputs 0, state=IDLE, RR pointer=1 (ch0 wins first), tag FIFO empty, counters 0.
- FSM states: IDLE, STREAM, GAP.
- IDLE -> STREAM when any Sx_VALID=1 and the tag FIFO is not full.
  - Arbitration is round-robin. If both request, the channel other than the last-granted one wins; a lone requester always wins.
  - On entry: the winner is latched, its ID is pushed to the tag FIFO, the sample counter is cleared, and the RR pointer is updated.
  - If the tag FIFO is full: stay in IDLE and grant nothing.
- STREAM lasts exactly N cycles.
  - Sx_READY=1 only for the granted channel, only in STREAM (registered state, combinational decode).
  - Each STREAM cycle, CORE_IEN<=1 and CORE_IREAL/IIMAG<=granted sample (registered, latency 1).
  - If the granted VALID=0: CORE_IREAL/IIMAG<=0, CORE_IEN stays 1, UNDERRUN set. The frame length is never shortened.
- Last STREAM cycle (count=N-1):
  - If MIN_GAP>0: go to GAP.
  - Else, if a request is pending and the FIFO is not full: re-arbitrate and stay in STREAM, so CORE_IEN stays high continuously.
  - Else: go to IDLE.
- GAP: CORE_IEN<=0 for MIN_GAP cycles, then IDLE.
- Output side:
  - An OEN counter counts CORE_OEN cycles modulo N.
  - O_CH=FIFO head, O_SOF=(cnt==0), O_EOF=(cnt==N-1). All are combinational from CORE_OEN, qualified by CORE_OEN=1; otherwise 0.
  - Pop on O_EOF.
  - Push and pop in the same cycle are both performed; the occupancy is unchanged.
- CORE_OEN=1 with the FIFO empty: TAG_ERR set, O_CH=0, O_SOF/O_EOF still follow the counter.
- Sticky flags clear only on reset.
- Reset mid-frame: immediate return to reset values. The partial frame is dropped, with no tag pushed.

Optional Feature:
- Macro FFT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, ch0 always wins simultaneous requests, and the RR pointer is unused.
- Undefined: round-robin as specified above.

Test Plan (FFT_STAGE=3, N=8, MIN_GAP=0):
- Only ch0 valid with 8 samples 1..8 -> CORE_IEN high for cycles 1..8 after grant, CORE_IREAL=1..8, S1_READY=0 throughout; model echoes 8 OEN -> O_CH=0, O_SOF on 1st, O_EOF on 8th.
- Both channels continuously valid -> frames alternate ch0, ch1, ch0, ch1 with CORE_IEN never dropping between frames; O_CH sequence matches grant order. With FFT_ARB_FIXED_PRIO_EN: all frames ch0.
- ch1 drops VALID for 2 cycles mid-frame -> 2 zero samples injected, frame still 8 cycles, UNDERRUN=1 and stays 1.
- Core output withheld with TAG_DEPTH=4 -> exactly 4 frames granted, then IDLE with READY=0. After one 8-cycle OEN burst, the 5th frame is granted.
- CORE_OEN pulsed with no frame issued -> TAG_ERR=1, O_CH=0.
- RSTN low at sample 5 of a frame -> next cycle all outputs 0, FIFO empty. After release, the next request is granted ch0.
